// File: rtl/sirc_pkg.sv
// ---------------------------------------------------------------------------
// sirc_pkg -- shared definitions for the Sony SIRC 12-bit IR transmitter.
//   sirc_state_e : FSM state encoding (IDLE, START, SPACE, MARK, FIN)
//   SIRC_BITS    : data bits per frame (7 command + 5 address)
//   TLEN_W       : width of the interval handed to the programmable timer
//   DEF_*        : default interval lengths in timer ticks (600us each)
//   mark_len()   : selects the mark interval for one data bit
// ---------------------------------------------------------------------------
package sirc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SPACE = 3'd2,
        ST_MARK  = 3'd3,
        ST_FIN   = 3'd4
    } sirc_state_e;

    localparam int SIRC_BITS  = 12;
    localparam int TLEN_W     = 17;
    localparam int BIT_CNT_W  = 4;

    localparam int DEF_START_UNITS  = 4;
    localparam int DEF_ONE_UNITS    = 2;
    localparam int DEF_ZERO_UNITS   = 1;
    localparam int DEF_SPACE_UNITS  = 1;
    localparam int DEF_CARRIER_HALF = 337;

    // A data bit of 1 is encoded as a long mark, 0 as a short mark.
    function automatic logic [TLEN_W-1:0] mark_len(
        input logic              bit_val,
        input logic [TLEN_W-1:0] one_len,
        input logic [TLEN_W-1:0] zero_len
    );
        return bit_val ? one_len : zero_len;
    endfunction

endpackage

// File: rtl/sirc_tx_if.sv
// ---------------------------------------------------------------------------
// sirc_tx_if -- request/status handshake between the lab control FSM and the
// SIRC transmitter.
//   send     : request a frame (sampled only while the transmitter is idle)
//   command  : 7-bit SIRC command, latched on accept
//   address  : 5-bit SIRC address, latched on accept
//   busy     : high from the cycle after accept until the done pulse
//   done     : one-cycle pulse after the final mark ends
// Modports: master = control FSM side, slave = transmitter side.
// ---------------------------------------------------------------------------
interface sirc_tx_if;
    logic       send;
    logic [6:0] command;
    logic [4:0] address;
    logic       busy;
    logic       done;

    modport master (output send, output command, output address,
                    input  busy, input  done);
    modport slave  (input  send, input  command, input  address,
                    output busy, output done);
endinterface

// File: rtl/sirc_carrier.sv
// ---------------------------------------------------------------------------
// sirc_carrier -- ~40kHz IR carrier generator, 50% duty.
//   clk      in  system clock (27MHz)
//   reset_n  in  asynchronous active-low reset
//   restart  in  restart phase: counter to 0, carrier high for the next half
//   carrier  out carrier level, period 2*HALF clk cycles, high half first
// Only instantiated when SIRC_CARRIER_EN is defined.
// ---------------------------------------------------------------------------
module sirc_carrier #(
    parameter int HALF = 337
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic carrier
);
    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt_r;
    logic          phase_r;

    // Half-period counter; phase flips each time a half-period completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r   <= '0;
            phase_r <= 1'b0;
        end else if (restart) begin
            cnt_r   <= '0;
            phase_r <= 1'b1;
        end else if (cnt_r == LAST) begin
            cnt_r   <= '0;
            phase_r <= ~phase_r;
        end else begin
            cnt_r   <= cnt_r + CW'(1);
        end
    end

    assign carrier = phase_r;
endmodule

// File: rtl/sirc_tx.sv
// ---------------------------------------------------------------------------
// sirc_tx -- Sony SIRC 12-bit IR transmitter FSM, sole client of the
// programmable timer.
//   clk            in   system clock, 27MHz
//   reset_n        in   asynchronous active-low reset
//   host           if   sirc_tx_if.slave (send/command/address/busy/done)
//   ir_out         out  IR LED drive
//   timer_start    out  one-cycle pulse, timer latches timer_length
//   timer_length   out  interval in timer ticks (always >= 1 when started)
//   timer_expired  in   one-cycle expiry pulse from the timer
// Frame: start mark, then per data bit (LSB first, command then address)
// a space followed by a long (1) or short (0) mark.
// Build option SIRC_CARRIER_EN: when defined, ir_out is the envelope gated
// by a ~40kHz carrier restarted on accept; when undefined, ir_out is the raw
// envelope and no carrier logic exists.
// ---------------------------------------------------------------------------
module sirc_tx
    import sirc_pkg::*;
#(
    parameter int START_UNITS  = DEF_START_UNITS,
    parameter int ONE_UNITS    = DEF_ONE_UNITS,
    parameter int ZERO_UNITS   = DEF_ZERO_UNITS,
`ifdef SIRC_CARRIER_EN
    parameter int CARRIER_HALF = DEF_CARRIER_HALF,
`endif
    parameter int SPACE_UNITS  = DEF_SPACE_UNITS
) (
    input  logic              clk,
    input  logic              reset_n,
    sirc_tx_if.slave          host,
    output logic              ir_out,
    output logic              timer_start,
    output logic [TLEN_W-1:0] timer_length,
    input  logic              timer_expired
);
    localparam logic [TLEN_W-1:0]    START_LEN = TLEN_W'(START_UNITS);
    localparam logic [TLEN_W-1:0]    ONE_LEN   = TLEN_W'(ONE_UNITS);
    localparam logic [TLEN_W-1:0]    ZERO_LEN  = TLEN_W'(ZERO_UNITS);
    localparam logic [TLEN_W-1:0]    SPACE_LEN = TLEN_W'(SPACE_UNITS);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(SIRC_BITS - 1);

    sirc_state_e          state_r;
    logic [SIRC_BITS-1:0] frame_r;
    logic [BIT_CNT_W-1:0] bit_cnt_r;
    logic                 env_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 timer_start_r;
    logic [TLEN_W-1:0]    timer_len_r;

    logic accept_s;
    logic expired_s;

    assign accept_s  = (state_r == ST_IDLE) && host.send;
    // An expiry coinciding with our own start pulse belongs to a stale interval.
    assign expired_s = timer_expired && !timer_start_r;

    // Frame sequencer: every interval state is entered with a one-cycle timer
    // start pulse and its length; the envelope is registered with the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            frame_r       <= '0;
            bit_cnt_r     <= '0;
            env_r         <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            timer_start_r <= 1'b0;
            timer_len_r   <= '0;
        end else begin
            timer_start_r <= 1'b0;
            done_r        <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        frame_r       <= {host.address, host.command};
                        bit_cnt_r     <= '0;
                        busy_r        <= 1'b1;
                        env_r         <= 1'b1;
                        timer_start_r <= 1'b1;
                        timer_len_r   <= START_LEN;
                        state_r       <= ST_START;
                    end
                end
                ST_START: begin
                    if (expired_s) begin
                        env_r         <= 1'b0;
                        timer_start_r <= 1'b1;
                        timer_len_r   <= SPACE_LEN;
                        state_r       <= ST_SPACE;
                    end
                end
                ST_SPACE: begin
                    if (expired_s) begin
                        env_r         <= 1'b1;
                        timer_start_r <= 1'b1;
                        timer_len_r   <= mark_len(frame_r[bit_cnt_r], ONE_LEN, ZERO_LEN);
                        state_r       <= ST_MARK;
                    end
                end
                ST_MARK: begin
                    if (expired_s) begin
                        env_r <= 1'b0;
                        if (bit_cnt_r == LAST_BIT) begin
                            state_r <= ST_FIN;
                        end else begin
                            bit_cnt_r     <= bit_cnt_r + 4'd1;
                            timer_start_r <= 1'b1;
                            timer_len_r   <= SPACE_LEN;
                            state_r       <= ST_SPACE;
                        end
                    end
                end
                ST_FIN: begin
                    // busy falls together with the done pulse, so a held send
                    // restarts after exactly one non-busy cycle.
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    env_r   <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign host.busy    = busy_r;
    assign host.done    = done_r;
    assign timer_start  = timer_start_r;
    assign timer_length = timer_len_r;

`ifdef SIRC_CARRIER_EN
    logic carrier_s;

    sirc_carrier #(.HALF(CARRIER_HALF)) u_carrier (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (accept_s),
        .carrier (carrier_s)
    );

    // Both operands are flops, so the drive is glitch-limited to the AND gate.
    assign ir_out = env_r & carrier_s;
`else
    assign ir_out = env_r;
`endif

endmodule
